// File: rtl/player_pkg.sv
// ---------------------------------------------------------------------------
// player_pkg
// Shared types and limits for the player power-up controller.
//   COUNT_W          width of every millisecond countdown
//   MAX_DURATION_MS  largest duration a countdown can hold
//   ms_count_t       countdown value type
//   pu_state_e       per-power-up FSM state encoding
//   duration_ok()    elaboration-time range check for duration parameters
// ---------------------------------------------------------------------------
package player_pkg;

  localparam int COUNT_W         = 13;
  localparam int MAX_DURATION_MS = (1 << COUNT_W) - 1;

  typedef logic [COUNT_W-1:0] ms_count_t;

  typedef enum logic {
    PU_IDLE   = 1'b0,
    PU_ACTIVE = 1'b1
  } pu_state_e;

  // A zero duration would enter ACTIVE with count 0 and wrap on the first
  // tick, so it is refused along with anything that overflows COUNT_W.
  function automatic bit duration_ok(input int ms);
    return (ms >= 1) && (ms <= MAX_DURATION_MS);
  endfunction

endpackage

// File: rtl/powerup_timer.sv
// ---------------------------------------------------------------------------
// powerup_timer
// One power-up: a two-state FSM with a millisecond down-counter.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   PU_IDLE   | power-up off, active = 0, count = 0
//   PU_ACTIVE | power-up on,  active = 1, count = remaining ms (1..DURATION)
//
// Ports
//   clock_100mhz  in   system clock
//   reset_n       in   synchronous active-low reset
//   load          in   pickup accepted: (re)load full DURATION
//   tick          in   one-cycle millisecond strobe
//   clear         in   round stopped: force IDLE
//   active        out  registered power-up flag
//   count         out  registered remaining milliseconds
// ---------------------------------------------------------------------------
module powerup_timer
  import player_pkg::*;
#(
  parameter int DURATION = 1
) (
  input  logic               clock_100mhz,
  input  logic               reset_n,
  input  logic               load,
  input  logic               tick,
  input  logic               clear,
  output logic               active,
  output logic [COUNT_W-1:0] count
);

  localparam ms_count_t FULL = ms_count_t'(DURATION);
  localparam ms_count_t ONE  = ms_count_t'(1);

  pu_state_e state;

  // Priority: reset/clear, then load, then tick. Load beating tick is what
  // lets a pickup on the expiry tick keep the power-up alive.
  always_ff @(posedge clock_100mhz) begin
    if (!reset_n || clear) begin
      state  <= PU_IDLE;
      active <= 1'b0;
      count  <= '0;
    end else if (load) begin
      state  <= PU_ACTIVE;
      active <= 1'b1;
      count  <= FULL;
    end else if (state == PU_ACTIVE && tick) begin
      if (count == ONE) begin
        state  <= PU_IDLE;
        active <= 1'b0;
        count  <= '0;
      end else begin
        count  <= count - ONE;
      end
    end
  end

endmodule

// File: rtl/player_powerup_ctrl.sv
// ---------------------------------------------------------------------------
// player_powerup_ctrl
// Invincibility and speed-boost timers for the player, plus collision
// filtering. A prescaler produces a millisecond strobe that drives two
// powerup_timer instances; hits are absorbed while invincible.
//
// Ports
//   clock_100mhz          in   system clock, rising edge
//   reset_n               in   synchronous active-low reset
//   game_active           in   high while a round runs
//   pickup_invincible     in   pulse: invincibility pickup
//   pickup_speedy         in   pulse: speed pickup
//   player_hit            in   pulse: obstacle collision
//   player_is_invincible  out  invincibility active
//   player_is_speedy      out  speed boost active
//   hit_taken             out  pulse: unabsorbed collision, one cycle later
//   invincible_ms_left    out  remaining invincibility ms
//   speedy_ms_left        out  remaining speed-boost ms
// ---------------------------------------------------------------------------
module player_powerup_ctrl
  import player_pkg::*;
#(
  parameter int CLK_PER_MS    = 100000,
  parameter int INVINCIBLE_MS = 5000,
  parameter int SPEEDY_MS     = 3000
) (
  input  logic               clock_100mhz,
  input  logic               reset_n,
  input  logic               game_active,
  input  logic               pickup_invincible,
  input  logic               pickup_speedy,
  input  logic               player_hit,
  output logic               player_is_invincible,
  output logic               player_is_speedy,
  output logic               hit_taken,
  output logic [COUNT_W-1:0] invincible_ms_left,
  output logic [COUNT_W-1:0] speedy_ms_left
);

  if (!duration_ok(INVINCIBLE_MS)) begin : g_bad_invincible
    $error("INVINCIBLE_MS must be within 1..%0d", MAX_DURATION_MS);
  end
  if (!duration_ok(SPEEDY_MS)) begin : g_bad_speedy
    $error("SPEEDY_MS must be within 1..%0d", MAX_DURATION_MS);
  end
  if (CLK_PER_MS < 1) begin : g_bad_prescale
    $error("CLK_PER_MS must be at least 1");
  end

  localparam int               PRE_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);

  logic [PRE_W-1:0] prescale;
  logic             ms_tick;

  // Strobe is decoded from the prescaler register; it only feeds the timer
  // registers, never an output directly.
  assign ms_tick = game_active && (prescale == PRE_LAST);

  always_ff @(posedge clock_100mhz) begin
    if (!reset_n || !game_active || ms_tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  powerup_timer #(
    .DURATION (INVINCIBLE_MS)
  ) u_invincible (
    .clock_100mhz (clock_100mhz),
    .reset_n      (reset_n),
    .load         (game_active && pickup_invincible),
    .tick         (ms_tick),
    .clear        (!game_active),
    .active       (player_is_invincible),
    .count        (invincible_ms_left)
  );

  powerup_timer #(
    .DURATION (SPEEDY_MS)
  ) u_speedy (
    .clock_100mhz (clock_100mhz),
    .reset_n      (reset_n),
    .load         (game_active && pickup_speedy),
    .tick         (ms_tick),
    .clear        (!game_active),
    .active       (player_is_speedy),
    .count        (speedy_ms_left)
  );

  // Uses the registered flag, i.e. the value before any same-cycle pickup.
  always_ff @(posedge clock_100mhz) begin
    if (!reset_n || !game_active) begin
      hit_taken <= 1'b0;
    end else begin
      hit_taken <= player_hit && !player_is_invincible;
    end
  end

endmodule

// File: doc/player_powerup_ctrl.md
PLAYER_POWERUP_CTRL -- requirements
Module: player_powerup_ctrl

Interface
REQ-001 Parameter CLK_PER_MS, default 100000: clock_100mhz cycles per millisecond tick.
REQ-002 Parameter INVINCIBLE_MS, default 5000: invincibility duration in ms.
REQ-003 Parameter SPEEDY_MS, default 3000: speed-boost duration in ms.
REQ-004 clock_100mhz  input  1  system clock, all logic on rising edge.
REQ-005 reset_n  input  1  reset; it SHALL be synchronous and active-low.
REQ-006 game_active  input  1  high while a round is running.
REQ-007 pickup_invincible  input  1  one-cycle pulse: invincibility pickup collected.
REQ-008 pickup_speedy  input  1  one-cycle pulse: speed pickup collected.
REQ-009 player_hit  input  1  one-cycle pulse: obstacle collision detected.
REQ-010 player_is_invincible  output  1  invincibility active; feeds the player display stage.
REQ-011 player_is_speedy  output  1  speed boost active; feeds the player display stage.
REQ-012 hit_taken  output  1  one-cycle pulse: collision not absorbed, life to be deducted.
REQ-013 invincible_ms_left  output  13  remaining invincibility ms.
REQ-014 speedy_ms_left  output  13  remaining speed-boost ms.

Function
REQ-015 The block SHALL derive a one-cycle ms_tick from a prescaler counting 0..CLK_PER_MS-1, pulsing on wrap.
REQ-016 The prescaler SHALL hold at 0 while game_active is low.
REQ-017 Each power-up SHALL run a two-state FSM: IDLE (flag 0, count 0) and ACTIVE (flag 1).
REQ-018 IDLE->ACTIVE on pickup pulse with game_active high: count loads full duration; flag high the next cycle (latency 1).
REQ-019 In ACTIVE, each ms_tick SHALL decrement count by 1.
REQ-020 ACTIVE->IDLE when ms_tick occurs with count == 1: count becomes 0 and flag low on the same edge.
REQ-021 Pickup while ACTIVE SHALL reload the full duration; durations never stack or exceed the parameter.
REQ-022 Pickup coinciding with the expiry tick SHALL take priority: state stays ACTIVE, count reloads.
REQ-023 Simultaneous pickup_invincible and pickup_speedy SHALL load both timers independently on the same edge.
REQ-024 hit_taken SHALL pulse one cycle after player_hit iff player_is_invincible is 0 at the player_hit cycle; otherwise the hit is absorbed and invincibility is unaffected.
REQ-025 player_hit on the same cycle as pickup_invincible SHALL be evaluated against the pre-pickup flag.
REQ-026 player_hit, pickups and ticks while game_active is low SHALL be ignored.
REQ-027 game_active falling SHALL force both FSMs to IDLE, counts to 0, flags and hit_taken to 0 on the next edge.
REQ-028 Count arithmetic SHALL be 13-bit unsigned; durations above 8191 SHALL be rejected at elaboration.

Reset
REQ-029 reset_n low SHALL, on the next rising edge, set prescaler 0, both FSMs IDLE, all outputs 0.
REQ-030 Reset mid-power-up SHALL discard remaining time; no pickup latched during reset is retained.

Structure
REQ-031 FSM state encodings and the 13-bit count width SHALL live in shared package player_pkg.
REQ-032 The per-power-up timer SHALL be sub-module powerup_timer (load, tick, clear -> active, count), instantiated twice.
REQ-033 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (CLK_PER_MS=10, INVINCIBLE_MS=5, SPEEDY_MS=3)
REQ-034 pickup_speedy at cycle 0 -> player_is_speedy high cycles 1..~31, speedy_ms_left 3,2,1,0 on successive ticks, low after third tick.
REQ-035 pickup_invincible, then pickup_invincible again on the tick where invincible_ms_left==1 -> count reloads to 5, flag never drops.
REQ-036 player_hit with invincibility active -> hit_taken stays 0; player_hit after expiry -> hit_taken high exactly one cycle.
REQ-037 Both pickups same cycle, then game_active low mid-run -> both flags and counts 0 next edge; pickups during game_active low ignored.
REQ-038 reset_n low for 1 cycle with speedy_ms_left==2 -> all outputs 0 next edge; prescaler restarts from 0.
